// File: rtl/fetch_stage.sv
// fetch_stage: pre-IF fetch for the mipsel32 pipeline.
// Owns the fetch PC, issues one instruction read at a time on an
// SRAM-like req/addr_ok/data_ok bus, buffers the returned word and
// hands {pc, inst, adel} downstream through a valid/allow handshake.
// Redirects cancel in-flight reads so stale words are never delivered.
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'hbfc00000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        inst_req,
  output logic [31:0] inst_addr,
  input  logic        inst_addr_ok,
  input  logic        inst_data_ok,
  input  logic [31:0] inst_rdata,
  output logic        valid_out,
  input  logic        allow_out,
  output logic [31:0] out_pc,
  output logic [31:0] out_inst,
  output logic        out_adel
);

  // REQ: presenting pc; WAIT: request accepted, awaiting data;
  // HOLD: buffer full, awaiting downstream.
  typedef enum logic [1:0] {
    REQ  = 2'd0,
    WAIT = 2'd1,
    HOLD = 2'd2
  } state_t;

  state_t      state;
  state_t      state_next;
  logic [31:0] pc;
  logic [31:0] pc_next;
  logic [31:0] req_pc;
  logic [31:0] req_pc_next;
  logic        cancel;
  logic        cancel_next;
  logic        load_buf;
  logic [31:0] buf_pc_next;
  logic [31:0] buf_inst_next;
  logic        buf_adel_next;
  logic        aligned;

  assign aligned = (pc[1:0] == 2'b00);

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= REQ;
    end else begin
      state <= state_next;
    end
  end

  // Datapath registers: fetch pc, accepted-request pc, cancel flag, hold buffer.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc       <= RESET_PC;
      req_pc   <= 32'd0;
      cancel   <= 1'b0;
      out_pc   <= 32'd0;
      out_inst <= 32'd0;
      out_adel <= 1'b0;
    end else begin
      pc     <= pc_next;
      req_pc <= req_pc_next;
      cancel <= cancel_next;
      if (load_buf) begin
        out_pc   <= buf_pc_next;
        out_inst <= buf_inst_next;
        out_adel <= buf_adel_next;
      end
    end
  end

  // Next-state and datapath update; a redirect always wins over delivery.
  always_comb begin
    state_next    = state;
    pc_next       = pc;
    req_pc_next   = req_pc;
    cancel_next   = cancel;
    load_buf      = 1'b0;
    buf_pc_next   = pc;
    buf_inst_next = 32'd0;
    buf_adel_next = 1'b0;
    case (state)
      REQ: begin
        if (!aligned) begin
          // Misaligned pc never reaches the bus; it is delivered as an
          // address-error slot unless a redirect replaces it first.
          if (redirect) begin
            pc_next = redirect_pc;
          end else begin
            load_buf      = 1'b1;
            buf_pc_next   = pc;
            buf_inst_next = 32'd0;
            buf_adel_next = 1'b1;
            pc_next       = pc + 32'd4;
            state_next    = HOLD;
          end
        end else if (inst_addr_ok) begin
          req_pc_next = pc;
          state_next  = WAIT;
          if (redirect) begin
            // The read is already on the bus; let it finish but drop the data.
            pc_next     = redirect_pc;
            cancel_next = 1'b1;
          end else begin
            pc_next = pc + 32'd4;
          end
        end else if (redirect) begin
          // Unaccepted request may simply change its address.
          pc_next = redirect_pc;
        end
      end
      WAIT: begin
        if (redirect) begin
          cancel_next = 1'b1;
          pc_next     = redirect_pc;
        end
        if (inst_data_ok) begin
          if (cancel || redirect) begin
            cancel_next = 1'b0;
            state_next  = REQ;
          end else begin
            load_buf      = 1'b1;
            buf_pc_next   = req_pc;
            buf_inst_next = inst_rdata;
            buf_adel_next = 1'b0;
            state_next    = HOLD;
          end
        end
      end
      HOLD: begin
        if (redirect) begin
          pc_next    = redirect_pc;
          state_next = REQ;
        end else if (allow_out) begin
          state_next = REQ;
        end
      end
      default: begin
        state_next = REQ;
      end
    endcase
  end

  // Bus request and downstream valid.
  always_comb begin
    inst_req  = (state == REQ) && aligned && !reset;
    inst_addr = pc;
    valid_out = (state == HOLD) && !redirect;
  end

endmodule
